// File: rtl/pedestrian_request_if.sv
// rtl/pedestrian_request_if.sv - button/controller signal bundle for the pedestrian request conditioner
interface pedestrian_request_if;
  logic       button_raw;
  logic       green_active;
  logic       request;
  logic       pending;
  logic [7:0] press_cnt;

  modport master (
    output button_raw,
    output green_active,
    input  request,
    input  pending,
    input  press_cnt
  );

  modport slave (
    input  button_raw,
    input  green_active,
    output request,
    output pending,
    output press_cnt
  );
endinterface

// File: rtl/pedestrian_request.sv
// rtl/pedestrian_request.sv - synchronise, debounce and latch pedestrian presses into a one-cycle request
module pedestrian_request #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MIN_GREEN       = 5000000,
  parameter int CNT_W           = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  pedestrian_request_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FIRE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_MAX = CNT_W'(MIN_GREEN);

  logic             s1;
  logic             s2;
  logic             db_level;
  logic             db_level_d;
  logic             press;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] green_cnt;
  logic [7:0]       press_cnt_q;
  logic             request_q;
  logic             request_nxt;
  state_t           state;
  state_t           state_nxt;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.button_raw;
      s2 <= s1;
    end
  end

  // Debounce: the level follows s2 only after it has differed for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (s2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= s2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Delayed debounced level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level_d <= 1'b0;
    end else begin
      db_level_d <= db_level;
    end
  end

  assign press = db_level & ~db_level_d;

  // Count every debounced press, absorbed ones included; wraps naturally at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_cnt_q <= 8'd0;
    end else if (press) begin
      press_cnt_q <= press_cnt_q + 8'd1;
    end
  end

  // Green timer: consecutive green cycles, saturating so it never wraps during a long green
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      green_cnt <= '0;
    end else if (!bus.green_active) begin
      green_cnt <= '0;
    end else if (green_cnt != GREEN_MAX) begin
      green_cnt <= green_cnt + 1'b1;
    end
  end

  // State and registered request pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      request_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      request_q <= request_nxt;
    end
  end

  // Next state: latch a press, fire once green has run long enough, re-arm if green vanished under the pulse
  always_comb begin
    state_nxt   = state;
    request_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (bus.green_active && (green_cnt == GREEN_MAX)) begin
          state_nxt   = FIRE;
          request_nxt = 1'b1;
        end
      end
      FIRE: begin
        state_nxt = bus.green_active ? IDLE : PENDING;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.request   = request_q;
  assign bus.pending   = (state != IDLE);
  assign bus.press_cnt = press_cnt_q;

endmodule
